ntt_stream_ctrl: RTL and testbench
==================================

NTT_STREAM_CTRL -- requirements
Module: ntt_stream_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, meaning coefficients per polynomial (power of 2).
REQ-002 SHALL have parameter DW, default 32, meaning coefficient width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning maximum cycles between result words.
REQ-004 SHALL have ports: ntt_clk_i in 1, clock; ntt_rst_i in 1, reset (one clock, synchronous, active-high).
REQ-005 SHALL have ports: start_i in 1, start request; mode_i in 2, transform select (00 Kyber NTT, 01 Kyber INTT, 10 Dilithium NTT, 11 Dilithium INTT).
REQ-006 SHALL have ports: src_addr_o out log2(N), source RAM address; src_rdata_i in DW, source data, valid one cycle after its address.
REQ-007 SHALL have ports: dst_we_o out 1; dst_addr_o out log2(N); dst_wdata_o out DW, result RAM write.
REQ-008 SHALL have ports: ntt_we_o out 1; ntt_addr_o out 32; ntt_wdata_o out DW, write side toward the NTT core.
REQ-009 SHALL have ports: ntt_rvalid_i in 1; ntt_rdata_i in DW, result stream from the NTT core.
REQ-010 SHALL have ports: busy_o out 1; done_o out 1, one-cycle pulse; err_o out 2, {proto, timeout}; cycles_o out 32, run length.

Function
REQ-011 SHALL implement states IDLE, CFG, LOAD, WAIT, DRAIN, DONE, ERR.
REQ-012 IDLE: start_i=1 -> CFG; cycle counter cleared to 0; err_o cleared.
REQ-013 CFG (1 cycle): ntt_we_o=1, ntt_addr_o=32'h4, ntt_wdata_o=zero-extended mode_i latched at start; src_addr_o=0; -> LOAD.
REQ-014 LOAD (exactly N cycles, beat k=0..N-1): ntt_we_o=1, ntt_addr_o=0, ntt_wdata_o=src_rdata_i (word k), src_addr_o=k+1 mod N; after beat N-1 -> WAIT.
REQ-015 WAIT/DRAIN: each cycle with ntt_rvalid_i=1 SHALL write dst_we_o=1, dst_addr_o=j, dst_wdata_o=ntt_rdata_i in the same cycle (combinational), j incrementing from 0; first rvalid moves WAIT -> DRAIN.
REQ-016 Gaps in ntt_rvalid_i during DRAIN SHALL be tolerated; j holds.
REQ-017 After the N-th result write -> DONE; DONE asserts done_o for exactly one cycle, then -> IDLE.
REQ-018 Idle counter SHALL reset on every rvalid and on entry to WAIT; reaching TIMEOUT in WAIT/DRAIN SHALL set err_o[0] and -> ERR.
REQ-019 ntt_rvalid_i=1 in IDLE, CFG or LOAD SHALL set err_o[1] (sticky until next start) and the word SHALL NOT be written to dst.
REQ-020 ERR SHALL hold until start_i=1, then behave as IDLE start; done_o is not pulsed for an errored run.
REQ-021 busy_o=1 in CFG, LOAD, WAIT, DRAIN; 0 otherwise.
REQ-022 start_i while busy_o=1 SHALL be ignored; mode_i SHALL be sampled only on accepted start.
REQ-023 cycles_o SHALL increment every cycle from CFG through the cycle of the last result write, saturate at 2^32-1, hold after DONE/ERR until next start.
REQ-024 Outside CFG/LOAD ntt_we_o=0, ntt_addr_o=0, ntt_wdata_o=0; outside DRAIN/WAIT result beats dst_we_o=0.
REQ-025 All outputs registered except dst_we_o, dst_addr_o, dst_wdata_o and ntt_wdata_o during LOAD.

Reset
REQ-026 ntt_rst_i=1 at any clock edge SHALL force IDLE, j=0, counters 0, err_o=0, cycles_o=0, busy_o=0, done_o=0, ntt_we_o=0, dst_we_o=0, src_addr_o=0, regardless of state.
REQ-027 Reset mid-LOAD or mid-DRAIN SHALL abort with no done_o pulse and no further dst writes.

Verification
REQ-028 Source RAM r[i]=i, mode=10, behavioural core returning r[i]+1 after 40 cycles contiguous -> one config write 32'h4/2, 256 data writes in order 0..255, dst[i]=i+1, one done_o pulse, err_o=0.
REQ-029 Core returns results with rvalid toggling 1/0 -> dst contents identical to contiguous case, cycles_o larger by 255.
REQ-030 Core never asserts rvalid, TIMEOUT=64 -> err_o=01 exactly 64 cycles after entering WAIT, busy_o=0, no done_o.
REQ-031 Spurious rvalid injected on LOAD beat 10 -> err_o[1]=1, dst unaffected by that word, run still completes with done_o.
REQ-032 start_i pulsed during DRAIN and reset asserted on LOAD beat 100 -> start ignored; after reset all outputs at reset values, next start runs cleanly from address 0.

Source files
------------

// File: rtl/ntt_stream_ctrl.sv
// Streams one polynomial from source RAM into an NTT core, then collects the
// transformed coefficients into result RAM, with timeout and protocol checking.
module ntt_stream_ctrl #(
   parameter int N       = 256,
   parameter int DW      = 32,
   parameter int TIMEOUT = 4096,
   localparam int AW     = $clog2(N)
) (
   input  logic          ntt_clk_i,
   input  logic          ntt_rst_i,
   input  logic          start_i,
   input  logic [1:0]    mode_i,
   output logic [AW-1:0] src_addr_o,
   input  logic [DW-1:0] src_rdata_i,
   output logic          dst_we_o,
   output logic [AW-1:0] dst_addr_o,
   output logic [DW-1:0] dst_wdata_o,
   output logic          ntt_we_o,
   output logic [31:0]   ntt_addr_o,
   output logic [DW-1:0] ntt_wdata_o,
   input  logic          ntt_rvalid_i,
   input  logic [DW-1:0] ntt_rdata_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [1:0]    err_o,
   output logic [31:0]   cycles_o
);

   typedef enum logic [2:0] {
      IDLE,
      CFG,
      LOAD,
      WAIT,
      DRAIN,
      DONE,
      ERR
   } state_t;

   state_t        state;
   logic [AW-1:0] beat_cnt;
   logic [AW-1:0] res_cnt;
   logic [31:0]   idle_cnt;
   logic [DW-1:0] cfg_wdata;
   logic          collecting;
   logic          counting;
   logic          spurious;

   assign collecting = (state == WAIT) || (state == DRAIN);
   assign counting   = (state == CFG) || (state == LOAD) || collecting;
   assign spurious   = ntt_rvalid_i && ((state == IDLE) || (state == CFG) || (state == LOAD));

   // Result beats go straight to the result RAM; a beat in the reset cycle is dropped.
   assign dst_we_o    = collecting && ntt_rvalid_i && !ntt_rst_i;
   assign dst_addr_o  = res_cnt;
   assign dst_wdata_o = ntt_rdata_i;

   // Source data arrives one cycle after its address, so LOAD forwards it unregistered.
   assign ntt_wdata_o = (state == LOAD) ? src_rdata_i : cfg_wdata;

   // Single controller: state, counters and all registered outputs.
   always_ff @(posedge ntt_clk_i) begin
      if (ntt_rst_i) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         res_cnt    <= '0;
         idle_cnt   <= '0;
         cfg_wdata  <= '0;
         src_addr_o <= '0;
         ntt_we_o   <= 1'b0;
         ntt_addr_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 2'b00;
         cycles_o   <= '0;
      end else begin
         done_o <= 1'b0;
         if (counting && (cycles_o != 32'hFFFF_FFFF)) begin
            cycles_o <= cycles_o + 32'd1;
         end

         case (state)
            IDLE, ERR: begin
               if (start_i) begin
                  state      <= CFG;
                  beat_cnt   <= '0;
                  res_cnt    <= '0;
                  idle_cnt   <= '0;
                  cfg_wdata  <= DW'(mode_i);
                  src_addr_o <= '0;
                  ntt_we_o   <= 1'b1;
                  ntt_addr_o <= 32'h4;
                  busy_o     <= 1'b1;
                  err_o      <= 2'b00;
                  cycles_o   <= '0;
               end
            end

            CFG: begin
               state      <= LOAD;
               cfg_wdata  <= '0;
               ntt_addr_o <= '0;
               src_addr_o <= AW'(1);
            end

            LOAD: begin
               beat_cnt   <= beat_cnt + AW'(1);
               src_addr_o <= src_addr_o + AW'(1);
               if (beat_cnt == AW'(N - 1)) begin
                  state      <= WAIT;
                  ntt_we_o   <= 1'b0;
                  src_addr_o <= '0;
                  idle_cnt   <= '0;
               end
            end

            WAIT, DRAIN: begin
               if (ntt_rvalid_i) begin
                  idle_cnt <= '0;
                  res_cnt  <= res_cnt + AW'(1);
                  state    <= DRAIN;
                  if (res_cnt == AW'(N - 1)) begin
                     state  <= DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end
               end else if (idle_cnt == 32'(TIMEOUT - 1)) begin
                  state    <= ERR;
                  busy_o   <= 1'b0;
                  err_o[0] <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase

         if (spurious) begin
            err_o[1] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Cycle-level bench: source RAM, result RAM and a behavioural NTT core that
// echoes each loaded word plus one after a fixed latency.
module tb_ntt_stream_ctrl;

   localparam int N       = 256;
   localparam int DW      = 32;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 40;

   localparam int PAT_CONTIG = 0;
   localparam int PAT_TOGGLE = 1;
   localparam int PAT_RANDOM = 2;
   localparam int PAT_NONE   = 3;

   logic          clk = 1'b0;
   logic          ntt_rst_i;
   logic          start_i;
   logic [1:0]    mode_i;
   logic [7:0]    src_addr_o;
   logic [DW-1:0] src_rdata_i;
   logic          dst_we_o;
   logic [7:0]    dst_addr_o;
   logic [DW-1:0] dst_wdata_o;
   logic          ntt_we_o;
   logic [31:0]   ntt_addr_o;
   logic [DW-1:0] ntt_wdata_o;
   logic          ntt_rvalid_i;
   logic [DW-1:0] ntt_rdata_i;
   logic          busy_o;
   logic          done_o;
   logic [1:0]    err_o;
   logic [31:0]   cycles_o;

   ntt_stream_ctrl #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .ntt_clk_i    (clk),
      .ntt_rst_i    (ntt_rst_i),
      .start_i      (start_i),
      .mode_i       (mode_i),
      .src_addr_o   (src_addr_o),
      .src_rdata_i  (src_rdata_i),
      .dst_we_o     (dst_we_o),
      .dst_addr_o   (dst_addr_o),
      .dst_wdata_o  (dst_wdata_o),
      .ntt_we_o     (ntt_we_o),
      .ntt_addr_o   (ntt_addr_o),
      .ntt_wdata_o  (ntt_wdata_o),
      .ntt_rvalid_i (ntt_rvalid_i),
      .ntt_rdata_i  (ntt_rdata_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .cycles_o     (cycles_o)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] src_mem  [N];
   logic [31:0] dst_mem  [N];
   logic [31:0] core_mem [N];

   int          cyc = 0;
   int          prev_addr = 0;
   int          dst_writes, cfg_writes, data_writes, data_bad, other_writes;
   logic [31:0] cfg_data;
   int          cfg_cyc, load_end_cyc, last_write_cyc, done_cnt, done_cyc, err_first_cyc;
   int          core_pat, core_out, spur_beat, rst_beat, drain_start_at;
   logic [1:0]  start_mode;
   bit          start_req, rst_fired;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearRun();
      for (int i = 0; i < N; i++) begin
         dst_mem[i]  = 32'hBAD0_0000;
         core_mem[i] = '0;
      end
      dst_writes = 0; cfg_writes = 0; data_writes = 0; data_bad = 0; other_writes = 0;
      cfg_data = '0; cfg_cyc = -1; load_end_cyc = -1; last_write_cyc = -1;
      done_cnt = 0; done_cyc = -1; err_first_cyc = -1;
      core_pat = PAT_NONE; core_out = 0; spur_beat = -1; rst_beat = -1; drain_start_at = -1;
      start_req = 1'b0; rst_fired = 1'b0;
   endtask

   task automatic fillSource(input bit ramp);
      for (int i = 0; i < N; i++) src_mem[i] = ramp ? 32'(i) : $urandom;
   endtask

   // One clock cycle: drive inputs after the falling edge, then observe the cycle.
   task automatic tick();
      logic is_beat;
      bit   fire;
      @(negedge clk);
      cyc++;
      is_beat = ntt_we_o && (ntt_addr_o == 32'h0);

      ntt_rst_i = 1'b0;
      if (rst_beat >= 0 && is_beat && data_writes == rst_beat) begin
         ntt_rst_i = 1'b1;
         rst_fired = 1'b1;
      end

      start_i = 1'b0;
      mode_i  = 2'($urandom_range(0, 3));
      if (start_req) begin
         start_i   = 1'b1;
         mode_i    = start_mode;
         start_req = 1'b0;
      end else if (drain_start_at >= 0 && dst_writes == drain_start_at && busy_o) begin
         start_i        = 1'b1;
         drain_start_at = -1;
      end

      src_rdata_i = src_mem[prev_addr];
      prev_addr   = int'(src_addr_o);

      ntt_rvalid_i = 1'b0;
      ntt_rdata_i  = '0;
      if (spur_beat >= 0 && is_beat && data_writes == spur_beat) begin
         ntt_rvalid_i = 1'b1;
         ntt_rdata_i  = 32'hDEAD_BEEF;
      end else if (load_end_cyc >= 0 && core_pat != PAT_NONE && core_out < N &&
                   cyc >= load_end_cyc + LAT) begin
         case (core_pat)
            PAT_CONTIG: fire = 1'b1;
            PAT_TOGGLE: fire = ((cyc - load_end_cyc - LAT) % 2) == 0;
            default:    fire = ($urandom_range(0, 2) != 0);
         endcase
         if (fire) begin
            ntt_rvalid_i = 1'b1;
            ntt_rdata_i  = core_mem[core_out] + 32'd1;
            core_out++;
         end
      end

      #1;
      if (ntt_we_o) begin
         if (ntt_addr_o == 32'h4) begin
            cfg_writes++;
            cfg_data = ntt_wdata_o;
            cfg_cyc  = cyc;
         end else if (ntt_addr_o == 32'h0) begin
            if (data_writes < N) begin
               core_mem[data_writes] = ntt_wdata_o;
               if (ntt_wdata_o !== src_mem[data_writes]) data_bad++;
            end
            data_writes++;
            if (data_writes == N) load_end_cyc = cyc;
         end else begin
            other_writes++;
         end
      end
      if (dst_we_o) begin
         dst_mem[int'(dst_addr_o)] = dst_wdata_o;
         dst_writes++;
         last_write_cyc = cyc;
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (err_o[0] && err_first_cyc < 0) err_first_cyc = cyc;
   endtask

   task automatic applyStimulus(input logic [1:0] mode, input int pat, input int spur, input int drain_start);
      clearRun();
      start_mode     = mode;
      start_req      = 1'b1;
      core_pat       = pat;
      spur_beat      = spur;
      drain_start_at = drain_start;
      for (int t = 0; t < 4000 && done_cnt == 0 && err_first_cyc < 0; t++) tick();
      repeat (4) tick();
   endtask

   task automatic checkRun(input string tag, input logic [1:0] mode, input logic [1:0] exp_err);
      int bad = 0;
      for (int i = 0; i < N; i++) if (dst_mem[i] !== src_mem[i] + 32'd1) bad++;
      checkOutput({tag, " done pulses"}, 32'(done_cnt), 32'd1);
      checkOutput({tag, " done timing"}, 32'(done_cyc - last_write_cyc), 32'd1);
      checkOutput({tag, " cfg writes"}, 32'(cfg_writes), 32'd1);
      checkOutput({tag, " cfg data"}, cfg_data, 32'(mode));
      checkOutput({tag, " load words"}, 32'(data_writes), 32'(N));
      checkOutput({tag, " load order"}, 32'(data_bad + other_writes), 32'd0);
      checkOutput({tag, " dst writes"}, 32'(dst_writes), 32'(N));
      checkOutput({tag, " dst contents"}, 32'(bad), 32'd0);
      checkOutput({tag, " err"}, 32'(err_o), 32'(exp_err));
      checkOutput({tag, " cycles"}, cycles_o, 32'(last_write_cyc - cfg_cyc + 1));
      checkOutput({tag, " busy after"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      logic [31:0] len_contig;
      logic [1:0]  m;

      ntt_rst_i = 1'b1; start_i = 1'b0; mode_i = 2'b00;
      src_rdata_i = '0; ntt_rvalid_i = 1'b0; ntt_rdata_i = '0;
      fillSource(1'b1);
      clearRun();
      repeat (3) @(negedge clk);
      tick();
      checkOutput("reset busy", 32'(busy_o), 32'd0);
      checkOutput("reset done", 32'(done_o), 32'd0);
      checkOutput("reset err", 32'(err_o), 32'd0);
      checkOutput("reset cycles", cycles_o, 32'd0);
      checkOutput("reset ntt_we", 32'(ntt_we_o), 32'd0);
      checkOutput("reset dst_we", 32'(dst_we_o), 32'd0);
      checkOutput("reset src_addr", 32'(src_addr_o), 32'd0);

      fillSource(1'b1);
      applyStimulus(2'b10, PAT_CONTIG, -1, -1);
      checkRun("contig", 2'b10, 2'b00);
      len_contig = cycles_o;

      applyStimulus(2'b10, PAT_TOGGLE, -1, -1);
      checkRun("toggle", 2'b10, 2'b00);
      checkOutput("toggle extra cycles", cycles_o - len_contig, 32'd255);

      for (int r = 0; r < 3; r++) begin
         fillSource(1'b0);
         m = 2'($urandom_range(0, 3));
         applyStimulus(m, PAT_RANDOM, -1, -1);
         checkRun("random", m, 2'b00);
      end

      fillSource(1'b0);
      applyStimulus(2'b01, PAT_CONTIG, 10, -1);
      checkRun("spurious", 2'b01, 2'b10);

      fillSource(1'b0);
      applyStimulus(2'b11, PAT_RANDOM, -1, 50);
      checkRun("start in drain", 2'b11, 2'b00);

      // Abort a run with reset in the middle of LOAD.
      fillSource(1'b1);
      clearRun();
      rst_beat   = 100;
      core_pat   = PAT_CONTIG;
      start_mode = 2'b01;
      start_req  = 1'b1;
      for (int t = 0; t < 1000 && !rst_fired; t++) tick();
      rst_beat = -1;
      tick();
      checkOutput("abort reset seen", 32'(rst_fired), 32'd1);
      checkOutput("abort busy", 32'(busy_o), 32'd0);
      checkOutput("abort done", 32'(done_o), 32'd0);
      checkOutput("abort err", 32'(err_o), 32'd0);
      checkOutput("abort cycles", cycles_o, 32'd0);
      checkOutput("abort ntt_we", 32'(ntt_we_o), 32'd0);
      checkOutput("abort ntt_addr", ntt_addr_o, 32'd0);
      checkOutput("abort src_addr", 32'(src_addr_o), 32'd0);
      repeat (60) tick();
      checkOutput("abort dst writes", 32'(dst_writes), 32'd0);
      checkOutput("abort done pulses", 32'(done_cnt), 32'd0);
      applyStimulus(2'b10, PAT_CONTIG, -1, -1);
      checkRun("after abort", 2'b10, 2'b00);

      fillSource(1'b0);
      applyStimulus(2'b00, PAT_NONE, -1, -1);
      checkOutput("timeout err", 32'(err_o), 32'd1);
      checkOutput("timeout latency", 32'(err_first_cyc - (load_end_cyc + 1)), 32'(TIMEOUT));
      checkOutput("timeout busy", 32'(busy_o), 32'd0);
      checkOutput("timeout done pulses", 32'(done_cnt), 32'd0);
      checkOutput("timeout dst writes", 32'(dst_writes), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
